// File: rtl/keypad_editor_pkg.sv
// keypad_editor_pkg: shared state encoding, key-width helper and "no key" sentinel
package keypad_editor_pkg;
    typedef enum logic [1:0] {
        SEL_CELL  = 2'd0,
        SEL_COLOR = 2'd1,
        COMMIT    = 2'd2
    } state_e;
    localparam logic [31:0] KEY_NONE = '1;
    function automatic int key_w(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction
endpackage

// File: rtl/keypad_scanner.sv
// keypad_scanner: column scan, per-frame lowest-key detect and press/release debounce
module keypad_scanner import keypad_editor_pkg::*; #(
    parameter int N_ROWS         = 4,
    parameter int N_COLS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    localparam int KW            = key_w(N_ROWS, N_COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_ROWS-1:0] fila,
    output logic [N_COLS-1:0] col,
    output logic [KW-1:0]     key_code,
    output logic              key_valid
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CIW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [KW:0] NONE = KEY_NONE[KW:0];
    logic [DW-1:0]  div_q, div_d;
    logic [CIW-1:0] col_idx_q, col_idx_d;
    logic [KW:0]    best_q, best_d, prev_q, prev_d, cand, low;
    logic [CW-1:0]  cnt_q, cnt_d, cnt_n;
    logic           pressed_q, pressed_d;
    logic [KW-1:0]  key_code_q, key_code_d;
    logic           key_valid_q, key_valid_d;
    logic           last, frame_end, hit, done, accept;
    always_comb begin
        cand = NONE;
        for (int r = N_ROWS - 1; r >= 0; r--)
            if (!fila[r]) cand = {1'b0, KW'(r * N_COLS + int'(col_idx_q))};
        low = (cand < best_q) ? cand : best_q;
        last = div_q == DW'(SCAN_DIV - 1);
        frame_end = last && col_idx_q == CIW'(N_COLS - 1);
        div_d = last ? '0 : div_q + 1'b1;
        col_idx_d = !last ? col_idx_q : (frame_end ? '0 : col_idx_q + 1'b1);
        best_d = !last ? best_q : (frame_end ? NONE : low);
        // while pressed we count release frames, otherwise frames repeating one code
        hit = pressed_q ? (low == NONE) : (low != NONE);
        cnt_n = !hit ? '0 : ((pressed_q || low == prev_q) ? cnt_q + 1'b1 : CW'(1));
        done = cnt_n == CW'(DEBOUNCE_SCANS);
        accept = frame_end && done && !pressed_q;
        cnt_d = !frame_end ? cnt_q : (done ? '0 : cnt_n);
        pressed_d = (frame_end && done) ? !pressed_q : pressed_q;
        prev_d = frame_end ? low : prev_q;
        key_code_d = accept ? low[KW-1:0] : key_code_q;
        key_valid_d = accept;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q       <= '0;
            col_idx_q   <= '0;
            best_q      <= NONE;
            prev_q      <= NONE;
            cnt_q       <= '0;
            pressed_q   <= 1'b0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            col_idx_q   <= col_idx_d;
            best_q      <= best_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            pressed_q   <= pressed_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end
    assign col       = ~(N_COLS'(1) << col_idx_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
endmodule

// File: rtl/keypad_cell_editor.sv
// keypad_cell_editor: keypad-driven select-cell/select-colour editor issuing single-cycle bank writes
module keypad_cell_editor import keypad_editor_pkg::*; #(
    parameter int N_ROWS         = 4,
    parameter int N_COLS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 3,
    parameter int CANCEL_KEY     = 15,
    localparam int KW            = key_w(N_ROWS, N_COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_ROWS-1:0] fila,
    output logic [N_COLS-1:0] col,
    output logic [KW-1:0]     key_code,
    output logic              key_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              busy
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d, wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              is_cancel, color_ok;
    keypad_scanner #(
        .N_ROWS(N_ROWS),
        .N_COLS(N_COLS),
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_scanner (
        .clk(clk),
        .rst(rst),
        .fila(fila),
        .col(col),
        .key_code(key_code),
        .key_valid(key_valid)
    );
    always_comb begin
        is_cancel = key_code == KW'(CANCEL_KEY);
        color_ok = (key_code >> DATA_W) == '0;
        state_d = state_q;
        cur_addr_d = cur_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d = state_q == COMMIT;
        if (state_q == COMMIT) begin
            state_d = SEL_CELL;
        end else if (key_valid && state_q == SEL_CELL && !is_cancel) begin
            cur_addr_d = ADDR_W'(key_code);
            state_d = SEL_COLOR;
        end else if (key_valid && state_q == SEL_COLOR) begin
            if (is_cancel) begin
                state_d = SEL_CELL;
            end else if (color_ok) begin
                wr_addr_d = cur_addr_q;
                wr_data_d = DATA_W'(key_code);
                state_d = COMMIT;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= SEL_CELL;
            cur_addr_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
        end
    end
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cur_addr = cur_addr_q;
    assign busy     = state_q == SEL_COLOR;
endmodule

// File: tb/tb_keypad_cell_editor.sv
// tb_keypad_cell_editor: directed checks of scan, debounce and edit FSM against a keypad model
module tb_keypad_cell_editor;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] fila, col, key_code, wr_addr, cur_addr;
    logic [2:0] wr_data;
    logic       key_valid, wr_en, busy;
    logic [15:0] keys;
    int n_tests = 0, n_fail = 0;
    int cyc = 0, kv_n = 0, kv_cyc = 0, wr_n = 0, wr_cyc = 0, ca_cyc = 0, k9, kv_before;
    logic [3:0] wa = '0, ca_prev = '0;
    logic [2:0] wd = '0;
    logic [3:0] walk [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    keypad_cell_editor #(
        .N_ROWS(4), .N_COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(2),
        .ADDR_W(4), .DATA_W(3), .CANCEL_KEY(15)
    ) dut (
        .clk(clk), .rst(rst), .fila(fila), .col(col), .key_code(key_code),
        .key_valid(key_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cur_addr(cur_addr), .busy(busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // keypad matrix: a pressed key pulls its row low while its column is driven
    always_comb begin
        fila = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) fila[r] = 1'b0;
    end
    always @(negedge clk) begin
        if (key_valid) begin
            kv_n = kv_n + 1;
            kv_cyc = cyc;
        end
        if (wr_en) begin
            wr_n = wr_n + 1;
            wr_cyc = cyc;
            wa = wr_addr;
            wd = wr_data;
        end
        if (cur_addr != ca_prev) ca_cyc = cyc;
        ca_prev = cur_addr;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic hold(input int k, input int frames);
        keys = 16'(1) << k;
        repeat (frames * 16) @(negedge clk);
    endtask
    task automatic idle(input int frames);
        keys = '0;
        repeat (frames * 16) @(negedge clk);
    endtask
    initial begin
        rst = 1'b0;
        keys = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_col", col, 4'b1110);
        check("rst_key_code", key_code, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_cur_addr", cur_addr, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("walk_hold", col, 4'b1110);
        for (int i = 0; i < 4; i++) begin
            repeat (i == 0 ? 1 : 4) @(posedge clk);
            @(negedge clk);
            check("walk", col, walk[i]);
        end
        hold(5, 3);
        check("press5_count", kv_n, 1);
        check("press5_code", key_code, 5);
        hold(5, 3);
        check("press5_norepeat", kv_n, 1);
        check("press5_busy", busy, 1);
        check("press5_cur", cur_addr, 5);
        idle(4);
        hold(15, 3);
        idle(4);
        check("cancel_count", kv_n, 2);
        check("cancel_code", key_code, 15);
        check("cancel_busy", busy, 0);
        check("cancel_cur_kept", cur_addr, 5);
        hold(9, 3);
        idle(4);
        k9 = kv_cyc;
        check("edit_cur", cur_addr, 9);
        check("edit_busy", busy, 1);
        check("edit_cur_lat", ca_cyc - k9, 1);
        hold(3, 3);
        idle(4);
        check("edit_kv_count", kv_n, 4);
        check("edit_wr_count", wr_n, 1);
        check("edit_wr_addr", wa, 9);
        check("edit_wr_data", wd, 3);
        check("edit_wr_lat", wr_cyc - kv_cyc, 2);
        check("edit_busy_after", busy, 0);
        check("edit_addr_hold", wr_addr, 9);
        hold(2, 3);
        idle(4);
        check("inv_cur", cur_addr, 2);
        check("inv_busy", busy, 1);
        hold(12, 3);
        idle(4);
        check("inv12_count", kv_n, 6);
        check("inv12_code", key_code, 12);
        check("inv12_busy", busy, 1);
        hold(15, 3);
        idle(4);
        check("inv_cancel_busy", busy, 0);
        check("inv_no_write", wr_n, 1);
        check("inv_cur_kept", cur_addr, 2);
        hold(15, 3);
        idle(4);
        check("idle_cancel_count", kv_n, 8);
        check("idle_cancel_busy", busy, 0);
        check("idle_cancel_cur", cur_addr, 2);
        kv_before = kv_n;
        for (int i = 0; i < 8; i++) begin
            keys = (i % 2 == 0) ? 16'h0080 : 16'h0000;
            repeat (16) @(negedge clk);
        end
        idle(4);
        check("bounce_no_kv", kv_n, kv_before);
        check("bounce_cur", cur_addr, 2);
        keys = 16'h0440;
        repeat (48) @(negedge clk);
        idle(4);
        check("multi_count", kv_n, 9);
        check("multi_code", key_code, 6);
        check("multi_cur", cur_addr, 6);
        check("multi_busy", busy, 1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cur", cur_addr, 0);
        check("mid_rst_code", key_code, 0);
        check("mid_rst_col", col, 4'b1110);
        check("mid_rst_wr_addr", wr_addr, 0);
        check("mid_rst_wr_data", wr_data, 0);
        rst = 1'b1;
        idle(6);
        check("mid_rst_no_write", wr_n, 1);
        check("mid_rst_no_kv", kv_n, 9);
        check("mid_rst_idle", busy, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/keypad_cell_editor.md
# keypad_cell_editor

Parametrised keypad-driven editor for the VGA colour register bank. It scans an R×C matrix keypad, debounces it, and decodes one accepted key per press. A two-step select-cell / select-colour state machine then issues a single-cycle write (address, colour) into the register bank. It replaces the switch-driven address/write-enable inputs at the top level and exports the current cursor for the 7-segment display.

## Interface
Parameters:
- N_ROWS, 4, keypad rows (fila inputs)
- N_COLS, 4, keypad columns (col outputs)
- SCAN_DIV, 50000, clock cycles each column is driven
- DEBOUNCE_SCANS, 4, consecutive identical frames needed to accept a press or a release
- ADDR_W, 4, register-bank address width
- DATA_W, 3, colour word width
- CANCEL_KEY, 15, key code that aborts a pending edit

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-low, single clock domain (clk)
- fila  in  N_ROWS  keypad rows, active-low (external pull-ups)
- col  out  N_COLS  column drive, one-hot active-low; reset N_COLS'b1…10 (column 0 driven)
- key_code  out  KW=clog2(N_ROWS*N_COLS)  last accepted key; reset 0
- key_valid  out  1  one-cycle pulse per accepted press; reset 0
- wr_en  out  1  one-cycle bank write strobe; reset 0
- wr_addr  out  ADDR_W  bank write address; reset 0
- wr_data  out  DATA_W  bank write colour; reset 0
- cur_addr  out  ADDR_W  selected cell, for the display; reset 0
- busy  out  1  high while in SEL_COLOR; reset 0

## Operation
- Scanner: the column index advances every SCAN_DIV cycles, wrapping N_COLS-1→0.
- fila is sampled on the last cycle of each column's dwell.
- Frame: N_COLS columns. Detected key = lowest row-major code (row*N_COLS+col) seen low in the frame; "none" if nothing is low.
- Multiple keys in one frame: the lowest code wins.
- Debounce, press: the same code in DEBOUNCE_SCANS consecutive frames → accept. key_code updates and key_valid pulses.
- No repeat: a new accept requires DEBOUNCE_SCANS consecutive "none" frames first. A different code without an intervening release is ignored.
- A glitch frame (different code or none) restarts the press count.
- FSM states: SEL_CELL, SEL_COLOR, COMMIT. Reset state is SEL_CELL.
  - SEL_CELL + key_valid, code≠CANCEL_KEY: cur_addr←code[ADDR_W-1:0], go to SEL_COLOR. A CANCEL_KEY press is ignored.
  - SEL_COLOR + key_valid, code==CANCEL_KEY: go to SEL_CELL, no write; cur_addr is kept.
  - SEL_COLOR + key_valid, code<2^DATA_W: latch wr_data←code, wr_addr←cur_addr, go to COMMIT.
  - SEL_COLOR + any other code: ignored, stay in SEL_COLOR.
  - COMMIT: wr_en=1 for exactly one cycle, then SEL_CELL unconditionally.
- wr_addr/wr_data hold their values after the write.
- Reset asserted mid-edit: every output returns to its reset value on that edge, the pending write is dropped, and debounce counters clear.

## Timing
- Frame length = N_COLS*SCAN_DIV cycles. Minimum press-to-key_valid = DEBOUNCE_SCANS frames, counted from the first frame that fully contains the press.
- key_valid is asserted the cycle after the sample that completes the count.
- The FSM reacts on the cycle after key_valid. wr_en rises 2 cycles after the colour key_valid, and cur_addr updates 1 cycle after the cell key_valid.
- key_valid can never pulse during COMMIT, because pulses are ≥ DEBOUNCE_SCANS frames apart.
- Width rules:
  - Key codes wider than ADDR_W are truncated.
  - Narrower codes are zero-extended.
  - Colour validity is compared at full KW width.

## Structure
- Package keypad_editor_pkg holds:
  - the state enum (SEL_CELL=2'd0, SEL_COLOR=2'd1, COMMIT=2'd2)
  - the KW computation function
  - the "none" sentinel constant
- Sub-module keypad_scanner (clk, rst, fila, col, key_code, key_valid) holds the scan counter, frame detect and debounce. The top of the block holds only the FSM and the output registers.

## Test plan
All scenarios use N_ROWS=N_COLS=4, SCAN_DIV=4, DEBOUNCE_SCANS=2 (frame = 16 cycles).
- Reset: hold rst=0 for 3 cycles → col=4'b1110, all other outputs 0, state SEL_CELL; after release, col walks 1110→1101→1011→0111 every 4 cycles.
- Single press: key 5 (row 1, col 1) held 3 frames → exactly one key_valid with key_code=5, no second pulse while held; after release ≥2 frames, the next press is accepted.
- Full edit: press 9, release, press 3 → cur_addr=9 and busy=1 after the first press; wr_en for 1 cycle with wr_addr=9, wr_data=3, 2 cycles after the second key_valid; busy=0 afterwards.
- Cancel and invalid: press 2, press 12 (≥8, ignored), press 15 → no wr_en, state SEL_CELL, cur_addr=2; press 15 in SEL_CELL → no state change.
- Bounce and multi-key: fila toggling every frame → no key_valid; keys 6 and 10 held together → accepted code 6.
- Mid-edit reset: rst=0 for 1 cycle while in SEL_COLOR → busy=0, cur_addr=0, no wr_en ever issued for the pending edit.
